funct_sequencer: RTL and testbench

Control sequencer for the R-type execution datapath: the ALU, shifter, HiLo multiplier and the output select mux. It accepts one funct code per request with a Start/Busy handshake and issues the datapath control strobes. Single-cycle ops (AND/OR/ADD/SUB/SLT/SLL/MFHI/MFLO) finish in one cycle. MULTU runs a counted multi-cycle shift-add sequence followed by a HiLo write. It drives the mux select (SignalOut) and a completion pulse (Done) to the surrounding control.

---
 rtl/funct_sequencer_if.sv | 24 ++
 rtl/funct_sequencer.sv | 142 ++++++++++++++
 tb/tb_funct_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/funct_sequencer_if.sv
// Request/strobe bundle between the surrounding control (master) and the
// R-type funct sequencer (slave).
interface funct_sequencer_if;
  logic       Start;
  logic [5:0] Funct;
  logic       Busy;
  logic       Done;
  logic       Illegal;
  logic [5:0] ALUCtrl;
  logic       MulInit;
  logic       MulStep;
  logic       HiLoWrite;
  logic [5:0] SignalOut;

  modport master (
    output Start, Funct,
    input  Busy, Done, Illegal, ALUCtrl, MulInit, MulStep, HiLoWrite, SignalOut
  );

  modport slave (
    input  Start, Funct,
    output Busy, Done, Illegal, ALUCtrl, MulInit, MulStep, HiLoWrite, SignalOut
  );
endinterface

// File: rtl/funct_sequencer.sv
// Control sequencer for the R-type datapath: single-cycle ALU/shift/HiLo-read
// ops and a counted shift-add MULTU followed by a HiLo write.
module funct_sequencer #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input logic              clk,
  input logic              rst_n,
  funct_sequencer_if.slave bus
);

  localparam int unsigned FW = 6;

  localparam logic [FW-1:0] F_AND   = 6'b100100;
  localparam logic [FW-1:0] F_OR    = 6'b100101;
  localparam logic [FW-1:0] F_ADD   = 6'b100000;
  localparam logic [FW-1:0] F_SUB   = 6'b100010;
  localparam logic [FW-1:0] F_SLT   = 6'b101010;
  localparam logic [FW-1:0] F_SLL   = 6'b000000;
  localparam logic [FW-1:0] F_MULTU = 6'b011001;
  localparam logic [FW-1:0] F_MFHI  = 6'b010000;
  localparam logic [FW-1:0] F_MFLO  = 6'b010010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MINIT,
    S_MSTEP,
    S_MWB
  } state_t;

  state_t          r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;
  logic            r_illegal, w_illegal_d;
  logic [FW-1:0]   r_alu_ctrl, w_alu_ctrl_d;
  logic            r_mul_init, w_mul_init_d;
  logic            r_mul_step, w_mul_step_d;
  logic            r_hilo_write, w_hilo_write_d;
  logic [FW-1:0]   r_signal_out, w_signal_out_d;
  logic            w_legal;

  // Funct decode for the single-cycle path
  always_comb begin
    w_legal = 1'b0;
    case (bus.Funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MULTU, F_MFHI, F_MFLO: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Outputs are computed for the next state so they register in step with it
  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_busy_d       = 1'b0;
    w_done_d       = 1'b0;
    w_illegal_d    = 1'b0;
    w_alu_ctrl_d   = r_alu_ctrl;
    w_mul_init_d   = 1'b0;
    w_mul_step_d   = 1'b0;
    w_hilo_write_d = 1'b0;
    w_signal_out_d = r_signal_out;

    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          w_alu_ctrl_d = bus.Funct;
          w_busy_d     = 1'b1;
          if (bus.Funct == F_MULTU) begin
            w_state_d    = S_MINIT;
            w_mul_init_d = 1'b1;
            w_cnt_d      = '0;
          end else begin
            w_state_d = S_EXEC;
            w_done_d  = 1'b1;
            if (w_legal) w_signal_out_d = bus.Funct;
            else         w_illegal_d    = 1'b1;
          end
        end
      end
      S_EXEC: w_state_d = S_IDLE;
      S_MINIT: begin
        w_state_d    = S_MSTEP;
        w_busy_d     = 1'b1;
        w_mul_step_d = 1'b1;
        w_cnt_d      = '0;
      end
      S_MSTEP: begin
        w_busy_d = 1'b1;
        if (r_cnt == CNT_W'(MUL_CYCLES - 1)) begin
          w_state_d      = S_MWB;
          w_hilo_write_d = 1'b1;
          w_done_d       = 1'b1;
          w_signal_out_d = F_MULTU;
        end else begin
          w_mul_step_d = 1'b1;
          w_cnt_d      = r_cnt + CNT_W'(1);
        end
      end
      S_MWB:   w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_illegal    <= 1'b0;
      r_alu_ctrl   <= '0;
      r_mul_init   <= 1'b0;
      r_mul_step   <= 1'b0;
      r_hilo_write <= 1'b0;
      r_signal_out <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_illegal    <= w_illegal_d;
      r_alu_ctrl   <= w_alu_ctrl_d;
      r_mul_init   <= w_mul_init_d;
      r_mul_step   <= w_mul_step_d;
      r_hilo_write <= w_hilo_write_d;
      r_signal_out <= w_signal_out_d;
    end
  end

  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Illegal   = r_illegal;
  assign bus.ALUCtrl   = r_alu_ctrl;
  assign bus.MulInit   = r_mul_init;
  assign bus.MulStep   = r_mul_step;
  assign bus.HiLoWrite = r_hilo_write;
  assign bus.SignalOut = r_signal_out;

endmodule

// File: tb/tb_funct_sequencer.sv
// Bench for funct_sequencer: directed vector table, hand-written multi-cycle
// sequences, and random traffic checked against a schedule-queue model.
module tb_funct_sequencer;

  localparam int MC = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  funct_sequencer_if bus();

  funct_sequencer #(.MUL_CYCLES(MC), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  // Word layout: busy, done, illegal, alu[5:0], init, step, hilo, sig[5:0]
  function automatic logic [17:0] act_word();
    return {bus.Busy, bus.Done, bus.Illegal, bus.ALUCtrl,
            bus.MulInit, bus.MulStep, bus.HiLoWrite, bus.SignalOut};
  endfunction

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] f);
    return f inside {6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
                     6'b000000, 6'b011001, 6'b010000, 6'b010010};
  endfunction

  // Reference model: each accepted request enqueues the per-cycle strobes it will produce
  typedef struct packed {
    logic       done, illegal, init, step, hilo, upd;
    logic [5:0] sig;
  } ev_t;

  ev_t        q[$];
  ev_t        m_cur  = '0;
  logic       m_busy = 1'b0;
  logic [5:0] m_alu  = '0;
  logic [5:0] m_sig  = '0;

  always @(posedge clk or negedge rst_n) begin
    ev_t e;
    if (!rst_n) begin
      q.delete();
      m_cur = '0; m_busy = 1'b0; m_alu = '0; m_sig = '0;
    end else begin
      if (!m_busy && bus.Start) begin
        m_alu = bus.Funct;
        if (bus.Funct == 6'b011001) begin
          e = '0; e.init = 1'b1; q.push_back(e);
          for (int i = 0; i < MC; i++) begin
            e = '0; e.step = 1'b1; q.push_back(e);
          end
          e = '0; e.hilo = 1'b1; e.done = 1'b1; e.upd = 1'b1; e.sig = 6'b011001;
          q.push_back(e);
        end else begin
          e = '0; e.done = 1'b1;
          e.illegal = !is_legal(bus.Funct);
          e.upd = is_legal(bus.Funct);
          e.sig = bus.Funct;
          q.push_back(e);
        end
      end
      if (q.size() > 0) begin
        m_cur = q.pop_front();
        m_busy = 1'b1;
        if (m_cur.upd) m_sig = m_cur.sig;
      end else begin
        m_cur = '0;
        m_busy = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && chk_en)
      check("model", act_word(),
            {m_busy, m_cur.done, m_cur.illegal, m_alu, m_cur.init, m_cur.step, m_cur.hilo, m_sig});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single request from idle; checks the Done cycle and the idle cycle after it
  task automatic issue(input string nm, input logic [5:0] f, input logic ill, input logic [5:0] sig);
    bus.Start = 1'b1;
    bus.Funct = f;
    tick();
    bus.Start = 1'b0;
    check(nm, act_word(), {1'b1, 1'b1, ill, f, 3'b000, sig});
    tick();
    check({nm, "_idle"}, act_word(), {1'b0, 1'b0, 1'b0, f, 3'b000, sig});
  endtask

  task automatic run_multu(input bit poke, input logic [5:0] prev_sig);
    logic [5:0]  s;
    logic [17:0] e;
    bus.Start = 1'b1;
    bus.Funct = 6'b011001;
    tick();
    bus.Start = 1'b0;
    for (int c = 1; c <= MC + 3; c++) begin
      s = (c >= MC + 2) ? 6'b011001 : prev_sig;
      e = {(c <= MC + 2), (c == MC + 2), 1'b0, 6'b011001,
           (c == 1), (c >= 2 && c <= MC + 1), (c == MC + 2), s};
      check(poke ? "multu_poke" : "multu", act_word(), e);
      if (poke && c == 8) begin
        bus.Start = 1'b1;
        bus.Funct = 6'b100100;
      end else begin
        bus.Start = 1'b0;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [5:0] funct;
    logic       ill;
    logic [5:0] sig;
  } vec_t;

  vec_t       tbl[11];
  logic [5:0] codes[9];

  initial begin
    tbl[0]  = '{6'b100000, 1'b0, 6'b100000};
    tbl[1]  = '{6'b111111, 1'b1, 6'b100000};
    tbl[2]  = '{6'b100100, 1'b0, 6'b100100};
    tbl[3]  = '{6'b000000, 1'b0, 6'b000000};
    tbl[4]  = '{6'b011010, 1'b1, 6'b000000};
    tbl[5]  = '{6'b010010, 1'b0, 6'b010010};
    tbl[6]  = '{6'b100101, 1'b0, 6'b100101};
    tbl[7]  = '{6'b101010, 1'b0, 6'b101010};
    tbl[8]  = '{6'b100010, 1'b0, 6'b100010};
    tbl[9]  = '{6'b010000, 1'b0, 6'b010000};
    tbl[10] = '{6'b000001, 1'b1, 6'b010000};
    codes = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
              6'b000000, 6'b011001, 6'b010000, 6'b010010};

    bus.Start = 1'b0;
    bus.Funct = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    check("reset", act_word(), 18'h0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    for (int i = 0; i < 11; i++)
      issue("table", tbl[i].funct, tbl[i].ill, tbl[i].sig);

    run_multu(1'b0, 6'b010000);
    run_multu(1'b1, 6'b011001);

    // Asynchronous reset in the middle of a multiply
    bus.Start = 1'b1;
    bus.Funct = 6'b011001;
    tick();
    bus.Start = 1'b0;
    repeat (13) tick();
    #2 rst_n = 1'b0;
    #1 check("async_reset", act_word(), 18'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", act_word(), 18'h0);
    end
    #2 rst_n = 1'b1;
    tick();
    issue("after_reset", 6'b010000, 1'b0, 6'b010000);

    // Back-to-back: Start held through the Done cycle with a new funct
    bus.Start = 1'b1;
    bus.Funct = 6'b100010;
    tick();
    check("b2b_first", act_word(), {1'b1, 1'b1, 1'b0, 6'b100010, 3'b000, 6'b100010});
    bus.Funct = 6'b101010;
    tick();
    check("b2b_gap", act_word(), {1'b0, 1'b0, 1'b0, 6'b100010, 3'b000, 6'b100010});
    tick();
    bus.Start = 1'b0;
    check("b2b_second", act_word(), {1'b1, 1'b1, 1'b0, 6'b101010, 3'b000, 6'b101010});
    tick();
    check("b2b_idle", act_word(), {1'b0, 1'b0, 1'b0, 6'b101010, 3'b000, 6'b101010});

    // Random traffic against the model, with occasional mid-cycle resets
    for (int n = 0; n < 4000; n++) begin
      bus.Start = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0) bus.Funct = 6'($urandom);
      else                           bus.Funct = codes[$urandom_range(0, 8)];
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rand_reset", act_word(), 18'h0);
        #2 rst_n = 1'b1;
      end
      tick();
    end

    bus.Start = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
